// File: rtl/invader_bullet_ctrl_if.sv
// Signal bundle between invader_bullet_ctrl and its neighbours: run/fire/ship
// inputs from the controls, live formation and bullet state out to formatVGA.
interface invader_bullet_ctrl_if;
   logic        enable;
   logic        fire;
   logic [4:0]  shipX;
   logic [19:0] invArray;
   logic [3:0]  invLine;
   logic [3:0]  bulletX;
   logic [2:0]  bulletY;
   logic        bulletFlying;
   logic        hit;
   logic        gameOver;
   logic        win;

   modport master (
      output enable, fire, shipX,
      input  invArray, invLine, bulletX, bulletY, bulletFlying, hit, gameOver, win
   );

   modport slave (
      input  enable, fire, shipX,
      output invArray, invLine, bulletX, bulletY, bulletFlying, hit, gameOver, win
   );
endinterface

// File: rtl/invader_bullet_ctrl.sv
// Game-state stage ahead of formatVGA: marching 2x10 invader formation, one
// player bullet, collision resolution and sticky win / game-over flags.
module invader_bullet_ctrl #(
   parameter int          BULLET_DIV = 1800000,
   parameter int          INV_DIV    = 36000000,
   parameter int          INV_COL0   = 3,
   parameter int          LINE_MAX   = 6,
   parameter logic [19:0] INIT_ARRAY = 20'hFFFFF
) (
   input logic                   clk,
   input logic                   clr,
   invader_bullet_ctrl_if.slave  bus
);

   localparam int BCW = $clog2(BULLET_DIV + 1);
   localparam int ICW = $clog2(INV_DIV + 1);

   typedef enum logic [1:0] {G_RUN, G_OVER, G_WON} game_e;
   typedef enum logic       {B_IDLE, B_FLY}        bullet_e;

   game_e            game_q,      game_d;
   bullet_e          bullet_q,    bullet_d;
   logic [19:0]      inv_array_q, inv_array_d;
   logic [3:0]       inv_line_q,  inv_line_d;
   logic [3:0]       bullet_x_q,  bullet_x_d;
   logic [2:0]       bullet_y_q,  bullet_y_d;
   logic             hit_q,       hit_d;
   logic [BCW-1:0]   bcnt_q,      bcnt_d;
   logic [ICW-1:0]   icnt_q,      icnt_d;

   logic             col_ok;
   logic [3:0]       col_idx;
   logic [9:0]       col_mask;
   logic             row0_hit;
   logic             row1_hit;
   logic             advance;
   logic             ship_lsb_unused;

   assign ship_lsb_unused = bus.shipX[0];
   assign advance         = bus.enable && (game_q == G_RUN);

   // Column under the bullet as a one-hot mask; empty when the bullet is outside the formation.
   assign col_ok   = (bullet_x_q >= 4'(INV_COL0)) && (bullet_x_q <= 4'(INV_COL0 + 9));
   assign col_idx  = bullet_x_q - 4'(INV_COL0);
   assign col_mask = col_ok ? (10'd1 << col_idx) : 10'd0;
   assign row1_hit = ({1'b0, bullet_y_q} == (inv_line_q + 4'd1)) && (|(inv_array_q[19:10] & col_mask));
   assign row0_hit = ({1'b0, bullet_y_q} == inv_line_q) && (|(inv_array_q[9:0] & col_mask));

   always_comb begin
      game_d      = game_q;
      bullet_d    = bullet_q;
      inv_array_d = inv_array_q;
      inv_line_d  = inv_line_q;
      bullet_x_d  = bullet_x_q;
      bullet_y_d  = bullet_y_q;
      bcnt_d      = bcnt_q;
      icnt_d      = icnt_q;
      hit_d       = 1'b0;

      if (advance) begin
         if (inv_array_q == 20'd0) begin
            game_d = G_WON;
         end else if (inv_line_q == 4'(LINE_MAX)) begin
            game_d = G_OVER;
         end

         if (icnt_q == ICW'(INV_DIV - 1)) begin
            icnt_d = '0;
            if (inv_line_q < 4'(LINE_MAX)) begin
               inv_line_d = inv_line_q + 4'd1;
            end
         end else begin
            icnt_d = icnt_q + ICW'(1);
         end

         // A collision retires the bullet before it is allowed to step or miss.
         case (bullet_q)
            B_IDLE: begin
               if (bus.fire) begin
                  bullet_d   = B_FLY;
                  bullet_x_d = bus.shipX[4:1];
                  bullet_y_d = 3'd6;
                  bcnt_d     = '0;
               end
            end
            B_FLY: begin
               if (row1_hit || row0_hit) begin
                  if (row1_hit) begin
                     inv_array_d[19:10] = inv_array_q[19:10] & ~col_mask;
                  end else begin
                     inv_array_d[9:0] = inv_array_q[9:0] & ~col_mask;
                  end
                  hit_d    = 1'b1;
                  bullet_d = B_IDLE;
               end else if (bcnt_q == BCW'(BULLET_DIV - 1)) begin
                  bcnt_d = '0;
                  if (bullet_y_q == 3'd0) begin
                     bullet_d = B_IDLE;
                  end else begin
                     bullet_y_d = bullet_y_q - 3'd1;
                  end
               end else begin
                  bcnt_d = bcnt_q + BCW'(1);
               end
            end
            default: begin
               bullet_d = B_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         game_q      <= G_RUN;
         bullet_q    <= B_IDLE;
         inv_array_q <= INIT_ARRAY;
         inv_line_q  <= 4'd0;
         bullet_x_q  <= 4'd0;
         bullet_y_q  <= 3'd0;
         hit_q       <= 1'b0;
         bcnt_q      <= '0;
         icnt_q      <= '0;
      end else begin
         game_q      <= game_d;
         bullet_q    <= bullet_d;
         inv_array_q <= inv_array_d;
         inv_line_q  <= inv_line_d;
         bullet_x_q  <= bullet_x_d;
         bullet_y_q  <= bullet_y_d;
         hit_q       <= hit_d;
         bcnt_q      <= bcnt_d;
         icnt_q      <= icnt_d;
      end
   end

   assign bus.invArray     = inv_array_q;
   assign bus.invLine      = inv_line_q;
   assign bus.bulletX      = bullet_x_q;
   assign bus.bulletY      = bullet_y_q;
   assign bus.bulletFlying = (bullet_q == B_FLY);
   assign bus.hit          = hit_q;
   assign bus.gameOver     = (game_q == G_OVER);
   assign bus.win          = (game_q == G_WON);

endmodule

// File: tb/tb_invader_bullet_ctrl.sv
// Bench for invader_bullet_ctrl: two instances (full formation and a single
// invader) checked every cycle against an integer game model plus fixed values.
module tb_invader_bullet_ctrl;

   localparam int BDIV = 4;
   localparam int IDIV = 64;
   localparam int COL0 = 3;
   localparam int LMAX = 6;

   typedef struct packed {
      logic [19:0] arr;
      int          line;
      int          bx;
      int          by;
      int          bcnt;
      int          icnt;
      bit          flying;
      bit          hit;
      bit          over;
      bit          won;
   } model_t;

   logic   clk = 1'b0;
   logic   clr;
   bit     checkOn;
   int     total = 0;
   int     bad = 0;
   model_t mA;
   model_t mB;

   invader_bullet_ctrl_if ifA ();
   invader_bullet_ctrl_if ifB ();

   invader_bullet_ctrl #(
      .BULLET_DIV(BDIV), .INV_DIV(IDIV), .INV_COL0(COL0), .LINE_MAX(LMAX), .INIT_ARRAY(20'hFFFFF)
   ) dutA (
      .clk(clk), .clr(clr), .bus(ifA)
   );

   invader_bullet_ctrl #(
      .BULLET_DIV(BDIV), .INV_DIV(IDIV), .INV_COL0(COL0), .LINE_MAX(LMAX), .INIT_ARRAY(20'h00001)
   ) dutB (
      .clk(clk), .clr(clr), .bus(ifB)
   );

   always #5 clk = ~clk;

   // Fresh game with a given formation.
   function automatic model_t modelReset(input logic [19:0] initArr);
      model_t m;
      m = '0;
      m.arr = initArr;
      return m;
   endfunction

   // One clock of the game rules, expressed on plain integers.
   function automatic model_t modelStep(input model_t m, input bit en, input bit fr, input logic [4:0] sx);
      model_t n;
      int     c;
      int     idx;
      n = m;
      n.hit = 1'b0;
      if (!en || m.over || m.won) return n;
      if (m.arr == 20'd0) n.won = 1'b1;
      else if (m.line == LMAX) n.over = 1'b1;
      if (m.icnt == IDIV - 1) begin
         n.icnt = 0;
         if (m.line < LMAX) n.line = m.line + 1;
      end else begin
         n.icnt = m.icnt + 1;
      end
      if (!m.flying) begin
         if (fr) begin
            n.flying = 1'b1;
            n.bx = int'(sx) / 2;
            n.by = 6;
            n.bcnt = 0;
         end
      end else begin
         c = m.bx - COL0;
         idx = -1;
         if (c >= 0 && c <= 9) begin
            if (m.by == m.line + 1 && m.arr[10 + c]) idx = 10 + c;
            else if (m.by == m.line && m.arr[c]) idx = c;
         end
         if (idx >= 0) begin
            n.arr[idx] = 1'b0;
            n.hit = 1'b1;
            n.flying = 1'b0;
         end else if (m.bcnt == BDIV - 1) begin
            n.bcnt = 0;
            if (m.by == 0) n.flying = 1'b0;
            else n.by = m.by - 1;
         end else begin
            n.bcnt = m.bcnt + 1;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         mA <= modelReset(20'hFFFFF);
         mB <= modelReset(20'h00001);
      end else begin
         mA <= modelStep(mA, ifA.enable, ifA.fire, ifA.shipX);
         mB <= modelStep(mB, ifB.enable, ifB.fire, ifB.shipX);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reportTimeout(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: timed out at %0t", name, $time);
   endtask

   task automatic compareUnit(input string tag, input model_t m, input logic [19:0] arr, input logic [3:0] line,
                              input logic [3:0] bx, input logic [2:0] by, input logic fl, input logic h,
                              input logic go, input logic w);
      checkOutput({tag, ".invArray"}, 32'(arr), 32'(m.arr));
      checkOutput({tag, ".invLine"}, 32'(line), 32'(m.line));
      checkOutput({tag, ".bulletX"}, 32'(bx), 32'(m.bx));
      checkOutput({tag, ".bulletY"}, 32'(by), 32'(m.by));
      checkOutput({tag, ".bulletFlying"}, 32'(fl), 32'(m.flying));
      checkOutput({tag, ".hit"}, 32'(h), 32'(m.hit));
      checkOutput({tag, ".gameOver"}, 32'(go), 32'(m.over));
      checkOutput({tag, ".win"}, 32'(w), 32'(m.won));
   endtask

   // Every cycle, both instances against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (checkOn) begin
         compareUnit("A", mA, ifA.invArray, ifA.invLine, ifA.bulletX, ifA.bulletY,
                     ifA.bulletFlying, ifA.hit, ifA.gameOver, ifA.win);
         compareUnit("B", mB, ifB.invArray, ifB.invLine, ifB.bulletX, ifB.bulletY,
                     ifB.bulletFlying, ifB.hit, ifB.gameOver, ifB.win);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit unitB, input bit en, input bit fr, input logic [4:0] sx);
      if (unitB) begin
         ifB.enable = en;
         ifB.fire   = fr;
         ifB.shipX  = sx;
      end else begin
         ifA.enable = en;
         ifA.fire   = fr;
         ifA.shipX  = sx;
      end
   endtask

   initial begin
      int n;
      int lineAtFire;
      logic [3:0] prevLine;
      clr = 1'b0;
      checkOn = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      tick(3);
      checkOn = 1'b1;
      checkOutput("rst A invArray", 32'(ifA.invArray), 32'h000FFFFF);
      checkOutput("rst A invLine", 32'(ifA.invLine), 32'd0);
      checkOutput("rst A bulletFlying", 32'(ifA.bulletFlying), 32'd0);
      checkOutput("rst A hit", 32'(ifA.hit), 32'd0);
      checkOutput("rst A gameOver", 32'(ifA.gameOver), 32'd0);
      checkOutput("rst A win", 32'(ifA.win), 32'd0);
      checkOutput("rst B invArray", 32'(ifB.invArray), 32'h00000001);

      clr = 1'b1;
      tick(63);
      checkOutput("march before wrap", 32'(ifA.invLine), 32'd0);
      tick(1);
      checkOutput("march after 64", 32'(ifA.invLine), 32'd1);

      applyStimulus(1'b0, 1'b1, 1'b1, 5'd10);
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd6);
      tick(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd10);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd6);
      checkOutput("fire A bulletX", 32'(ifA.bulletX), 32'd5);
      checkOutput("fire A bulletY", 32'(ifA.bulletY), 32'd6);
      checkOutput("fire A flying", 32'(ifA.bulletFlying), 32'd1);
      checkOutput("fire B bulletX", 32'(ifB.bulletX), 32'd3);

      tick(16);
      checkOutput("A row2 bulletY", 32'(ifA.bulletY), 32'd2);
      checkOutput("A row2 hit", 32'(ifA.hit), 32'd0);
      tick(1);
      checkOutput("A hit pulse", 32'(ifA.hit), 32'd1);
      checkOutput("A bit12 cleared", 32'(ifA.invArray), 32'h000FEFFF);
      checkOutput("A retired", 32'(ifA.bulletFlying), 32'd0);
      checkOutput("A bulletY held", 32'(ifA.bulletY), 32'd2);
      tick(1);
      checkOutput("A hit one cycle", 32'(ifA.hit), 32'd0);

      tick(3);
      checkOutput("B hit pulse", 32'(ifB.hit), 32'd1);
      checkOutput("B array empty", 32'(ifB.invArray), 32'd0);
      checkOutput("B win not yet", 32'(ifB.win), 32'd0);
      tick(1);
      checkOutput("B win", 32'(ifB.win), 32'd1);

      applyStimulus(1'b0, 1'b1, 1'b1, 5'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd20);
      tick(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd20);
      checkOutput("miss A bulletX", 32'(ifA.bulletX), 32'd0);
      checkOutput("miss A bulletY", 32'(ifA.bulletY), 32'd6);
      checkOutput("B fire after win", 32'(ifB.bulletFlying), 32'd0);
      tick(4);
      checkOutput("miss A step", 32'(ifA.bulletY), 32'd5);
      applyStimulus(1'b0, 1'b1, 1'b1, 5'd31);
      tick(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd31);
      checkOutput("refire bulletX", 32'(ifA.bulletX), 32'd0);
      checkOutput("refire bulletY", 32'(ifA.bulletY), 32'd5);
      tick(19);
      checkOutput("miss row0", 32'(ifA.bulletY), 32'd0);
      checkOutput("miss row0 flying", 32'(ifA.bulletFlying), 32'd1);
      tick(3);
      checkOutput("miss last wait", 32'(ifA.bulletFlying), 32'd1);
      tick(1);
      checkOutput("miss retired", 32'(ifA.bulletFlying), 32'd0);
      checkOutput("miss array", 32'(ifA.invArray), 32'h000FEFFF);
      checkOutput("miss hit", 32'(ifA.hit), 32'd0);

      applyStimulus(1'b0, 1'b1, 1'b1, 5'd0);
      tick(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
      tick(5);
      checkOutput("pre-freeze bulletY", 32'(ifA.bulletY), 32'd5);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
      tick(10);
      checkOutput("frozen bulletY", 32'(ifA.bulletY), 32'd5);
      checkOutput("frozen flying", 32'(ifA.bulletFlying), 32'd1);
      checkOutput("frozen invLine", 32'(ifA.invLine), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
      n = 0;
      while (ifA.bulletFlying === 1'b1 && n < 60) begin
         tick(1);
         n++;
      end
      if (n >= 60) reportTimeout("resume flight");

      // Launch so the row-1 collision lands on the formation-step edge.
      n = 0;
      while (!(mA.icnt == 62 - 4 * (5 - mA.line) && !mA.flying && mA.line <= 4) && n < 200) begin
         tick(1);
         n++;
      end
      if (n >= 200) reportTimeout("align wait");
      lineAtFire = mA.line;
      applyStimulus(1'b0, 1'b1, 1'b1, 5'd14);
      tick(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd14);
      n = 0;
      prevLine = ifA.invLine;
      while (ifA.hit !== 1'b1 && n < 40) begin
         prevLine = ifA.invLine;
         tick(1);
         n++;
      end
      if (n >= 40) reportTimeout("samecycle hit");
      checkOutput("samecycle prevLine", 32'(prevLine), 32'(lineAtFire));
      checkOutput("samecycle invLine", 32'(ifA.invLine), 32'(lineAtFire + 1));
      checkOutput("samecycle array", 32'(ifA.invArray), 32'h000FAFFF);

      n = 0;
      while (ifA.invLine !== 4'd6 && n < 500) begin
         tick(1);
         n++;
      end
      if (n >= 500) reportTimeout("reach line 6");
      checkOutput("line6 gameOver early", 32'(ifA.gameOver), 32'd0);
      tick(1);
      checkOutput("gameOver set", 32'(ifA.gameOver), 32'd1);
      tick(70);
      checkOutput("over invLine frozen", 32'(ifA.invLine), 32'd6);
      checkOutput("over array", 32'(ifA.invArray), 32'h000FAFFF);
      applyStimulus(1'b0, 1'b1, 1'b1, 5'd10);
      tick(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd10);
      tick(1);
      checkOutput("over fire ignored", 32'(ifA.bulletFlying), 32'd0);
      checkOutput("B line frozen", 32'(ifB.invLine), 32'd1);
      checkOutput("B win sticky", 32'(ifB.win), 32'd1);

      clr = 1'b0;
      #1;
      checkOutput("clr A invArray", 32'(ifA.invArray), 32'h000FFFFF);
      checkOutput("clr A invLine", 32'(ifA.invLine), 32'd0);
      checkOutput("clr A gameOver", 32'(ifA.gameOver), 32'd0);
      checkOutput("clr A bulletY", 32'(ifA.bulletY), 32'd0);
      checkOutput("clr B win", 32'(ifB.win), 32'd0);
      checkOutput("clr B invArray", 32'(ifB.invArray), 32'h00000001);
      tick(2);
      clr = 1'b1;
      tick(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
